// File: rtl/lcb_responder.sv
// rtl/lcb_responder.sv - multi-channel LCB request/answer engine between UART rx and tx
// Parses {addr, cmd} frames, streams a per-channel ROM answer, drives RS485 direction.
module lcb_responder #(
   parameter int         N_CH       = 4,
   parameter int         CH_W       = 2,
   parameter logic [7:0] ADDR_BASE  = 8'h10,
   parameter int         ANS_LEN    = 16,
   parameter int         IDX_W      = 4,
   parameter int         TURN_CYC   = 160,
   parameter int         GUARD_CYC  = 80,
   parameter int         RX_TIMEOUT = 800,
   parameter bit         ECHO_EN    = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   output logic [CH_W+IDX_W-1:0]  rom_addr,
   input  logic [7:0]             rom_data,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic                   dir_tx,
   output logic                   dir_rx,
   output logic                   req,
   output logic [CH_W-1:0]        ch_id,
   output logic                   busy,
   output logic [7:0]             err_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_GOT_ADDR, S_TURN, S_FETCH, S_LOAD, S_SEND, S_WAIT_TX, S_GUARD
   } state_t;

   state_t                  state_q, state_d;
   logic [15:0]             cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [7:0]              cmd_q, cmd_d;
   logic [7:0]              tx_data_q, tx_data_d;
   logic [7:0]              err_q, err_d;
   logic [CH_W+IDX_W-1:0]   rom_addr_q, rom_addr_d;
   logic                    tx_start_q, tx_start_d;
   logic                    dir_tx_q, dir_tx_d, dir_rx_q;
   logic                    req_q, req_d, busy_q;
   logic [8:0]              addr_off;
   logic                    in_window, err_inc, half_duplex;

   // Addresses below the base wrap to a large 9-bit value and fall out of the window.
   assign addr_off    = {1'b0, rx_data} - {1'b0, ADDR_BASE};
   assign in_window   = addr_off < 9'(N_CH);
   assign half_duplex = (state_q != S_IDLE) && (state_q != S_GOT_ADDR);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      ch_d       = ch_q;
      cmd_d      = cmd_q;
      tx_data_d  = tx_data_q;
      rom_addr_d = rom_addr_q;
      tx_start_d = 1'b0;
      dir_tx_d   = dir_tx_q;
      req_d      = 1'b0;
      err_inc    = 1'b0;
      case (state_q)
         S_IDLE: begin
            dir_tx_d = 1'b0;
            if (rx_valid && in_window) begin
               ch_d    = addr_off[CH_W-1:0];
               cnt_d   = '0;
               state_d = S_GOT_ADDR;
            end
         end
         S_GOT_ADDR: begin
            if (rx_valid) begin
               cmd_d   = rx_data;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_TURN;
            end else if (cnt_q == 16'(RX_TIMEOUT - 1)) begin
               err_inc = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         // The req cycle is the first turnaround cycle; FETCH/LOAD/SEND complete the delay.
         S_TURN: begin
            dir_tx_d = 1'b1;
            if (cnt_q == 16'(TURN_CYC - 2)) begin
               idx_d      = '0;
               rom_addr_d = {ch_q, idx_d};
               state_d    = S_FETCH;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            tx_data_d = (ECHO_EN && idx_q == '0) ? cmd_q : rom_data;
            state_d   = S_SEND;
         end
         S_SEND: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               state_d    = S_WAIT_TX;
            end
         end
         S_WAIT_TX: begin
            if (!tx_start_q && !tx_busy) begin
               if (idx_q == IDX_W'(ANS_LEN - 1)) begin
                  cnt_d   = '0;
                  state_d = S_GUARD;
               end else begin
                  idx_d      = idx_q + 1'b1;
                  rom_addr_d = {ch_q, idx_d};
                  state_d    = S_FETCH;
               end
            end
         end
         S_GUARD: begin
            if (cnt_q == 16'(GUARD_CYC - 2)) begin
               dir_tx_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (rx_valid && half_duplex) err_inc = 1'b1;
      err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         ch_q       <= '0;
         cmd_q      <= '0;
         tx_data_q  <= '0;
         err_q      <= '0;
         rom_addr_q <= '0;
         tx_start_q <= 1'b0;
         dir_tx_q   <= 1'b0;
         dir_rx_q   <= 1'b1;
         req_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         ch_q       <= ch_d;
         cmd_q      <= cmd_d;
         tx_data_q  <= tx_data_d;
         err_q      <= err_d;
         rom_addr_q <= rom_addr_d;
         tx_start_q <= tx_start_d;
         dir_tx_q   <= dir_tx_d;
         dir_rx_q   <= ~dir_tx_d;
         req_q      <= req_d;
         busy_q     <= (state_d != S_IDLE);
      end
   end

   assign rom_addr = rom_addr_q;
   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign dir_tx   = dir_tx_q;
   assign dir_rx   = dir_rx_q;
   assign req      = req_q;
   assign ch_id    = ch_q;
   assign busy     = busy_q;
   assign err_cnt  = err_q;

endmodule

// File: tb/tb_lcb_responder.sv
// tb/tb_lcb_responder.sv - directed self-checking bench for lcb_responder
// Two instances share the rx stream: dut0 plain answers, dut1 with command echo.
module tb_lcb_responder;

   localparam int TURN_CYC  = 160;
   localparam int GUARD_CYC = 80;
   localparam int BYTE_CYC  = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_valid;
   logic [7:0] rx_data;

   logic [5:0] rom_a0, rom_a1;
   logic [7:0] rom_d0, rom_d1, txd0, txd1, err0, err1;
   logic       txs0, txs1, txb0, txb1, dtx0, dtx1, drx0, drx1, req0, req1, busy0, busy1;
   logic [1:0] ch0, ch1;
   int         bcnt0 = 0, bcnt1 = 0;

   always #5 clk = ~clk;

   lcb_responder dut0 (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rom_addr(rom_a0), .rom_data(rom_d0), .tx_data(txd0), .tx_start(txs0),
      .tx_busy(txb0), .dir_tx(dtx0), .dir_rx(drx0), .req(req0), .ch_id(ch0),
      .busy(busy0), .err_cnt(err0)
   );

   lcb_responder #(.ECHO_EN(1'b1)) dut1 (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .rom_addr(rom_a1), .rom_data(rom_d1), .tx_data(txd1), .tx_start(txs1),
      .tx_busy(txb1), .dir_tx(dtx1), .dir_rx(drx1), .req(req1), .ch_id(ch1),
      .busy(busy1), .err_cnt(err1)
   );

   function automatic logic [7:0] rom_val(input logic [5:0] a);
      return 8'(a * 7) ^ 8'h5C;
   endfunction

   // Synchronous ROMs and fixed-length UART transmitter models
   always @(posedge clk) begin
      rom_d0 <= rom_val(rom_a0);
      rom_d1 <= rom_val(rom_a1);
      bcnt0  <= txs0 ? BYTE_CYC : (bcnt0 > 0 ? bcnt0 - 1 : 0);
      bcnt1  <= txs1 ? BYTE_CYC : (bcnt1 > 0 ? bcnt1 - 1 : 0);
   end
   assign txb0 = (bcnt0 != 0);
   assign txb1 = (bcnt1 != 0);

   int         cyc = 0;
   logic [7:0] log0 [0:255];
   logic [7:0] log1 [0:255];
   int         txc0 [0:255];
   int         tx_n0 = 0, tx_n1 = 0, req_n0 = 0, req_n1 = 0;
   int         req_cyc = 0, req_ch = 0, dir_rise = 0, dir_fall = 0, busy_fall = 0, dir_bad = 0;
   logic       dir_prev = 1'b0, txb_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (req0) begin req_n0 = req_n0 + 1; req_cyc = cyc; req_ch = int'(ch0); end
         if (req1) req_n1 = req_n1 + 1;
         if (txs0 && tx_n0 < 256) begin log0[tx_n0] = txd0; txc0[tx_n0] = cyc; tx_n0 = tx_n0 + 1; end
         if (txs1 && tx_n1 < 256) begin log1[tx_n1] = txd1; tx_n1 = tx_n1 + 1; end
         if (dtx0 && !dir_prev) dir_rise = cyc;
         if (!dtx0 && dir_prev) dir_fall = cyc;
         if (!txb0 && txb_prev) busy_fall = cyc;
         if (drx0 !== ~dtx0 || drx1 !== ~dtx1) dir_bad = dir_bad + 1;
         dir_prev = dtx0;
         txb_prev = txb0;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!busy0 && !busy1) break;
      end
      check(tag, {31'b0, busy0 | busy1}, 32'd0);
      repeat (5) @(negedge clk);
   endtask

   task automatic wait_tx(input int n, input string tag);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (tx_n0 >= n) break;
      end
      check(tag, 32'(tx_n0 >= n), 32'd1);
   endtask

   int b0, b1, r0, bad;

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_dir_tx",   {31'b0, dtx0},  32'd0);
      check("rst_dir_rx",   {31'b0, drx0},  32'd1);
      check("rst_busy",     {31'b0, busy0}, 32'd0);
      check("rst_tx_start", {31'b0, txs0},  32'd0);
      check("rst_req",      {31'b0, req0},  32'd0);
      check("rst_outs",     {8'h0, txd0, 6'h0, rom_a0, 6'h0, ch0, err0}, 32'd0);

      // 1: plain request to channel 2
      b0 = tx_n0; r0 = req_n0;
      send_byte(8'h12); send_byte(8'hA5);
      wait_idle("t1_idle");
      check("t1_req_cnt", 32'(req_n0 - r0), 32'd1);
      check("t1_ch_id",   32'(req_ch), 32'd2);
      check("t1_dir_rise", 32'(dir_rise - req_cyc), 32'd1);
      check("t1_first_start", 32'(txc0[b0] - req_cyc), 32'(TURN_CYC + 2));
      check("t1_tx_cnt",  32'(tx_n0 - b0), 32'd16);
      bad = 0;
      for (int i = 0; i < 16; i++) if (log0[b0 + i] !== rom_val({2'd2, 4'(i)})) bad++;
      check("t1_tx_data", 32'(bad), 32'd0);
      check("t1_guard",   32'(dir_fall - busy_fall), 32'(GUARD_CYC));
      check("t1_err",     {24'b0, err0}, 32'd0);

      // 2: out-of-window address ignored, then channel 3
      r0 = req_n0;
      send_byte(8'h20);
      repeat (5) @(negedge clk);
      check("t2_no_req",  32'(req_n0 - r0), 32'd0);
      check("t2_no_busy", {31'b0, busy0}, 32'd0);
      b0 = tx_n0;
      send_byte(8'h13); send_byte(8'h01);
      wait_idle("t2_idle");
      check("t2_ch_id",   32'(req_ch), 32'd3);
      check("t2_tx_cnt",  32'(tx_n0 - b0), 32'd16);
      check("t2_last",    {24'b0, log0[b0 + 15]}, {24'b0, rom_val(6'h3F)});
      check("t2_err",     {24'b0, err0}, 32'd0);

      // 3: address then silence -> timeout
      r0 = req_n0;
      send_byte(8'h11);
      repeat (795) @(negedge clk);
      check("t3_still_wait", {31'b0, busy0}, 32'd1);
      repeat (10) @(negedge clk);
      check("t3_timeout_idle", {31'b0, busy0}, 32'd0);
      check("t3_no_req",  32'(req_n0 - r0), 32'd0);
      check("t3_err",     {24'b0, err0}, 32'd1);

      // 3/4: next full frame to ch 0, echo instance answers with the command first
      b0 = tx_n0; b1 = tx_n1; r0 = req_n1;
      send_byte(8'h10); send_byte(8'h5A);
      wait_idle("t4_idle");
      check("t3_after_ch",  32'(req_ch), 32'd0);
      check("t3_after_b0",  {24'b0, log0[b0]}, {24'b0, rom_val(6'h00)});
      check("t4_echo_req",  32'(req_n1 - r0), 32'd1);
      check("t4_echo_b0",   {24'b0, log1[b1]}, 32'h5A);
      bad = 0;
      for (int i = 1; i < 16; i++) if (log1[b1 + i] !== rom_val({2'd0, 4'(i)})) bad++;
      check("t4_echo_rest", 32'(bad), 32'd0);
      check("t4_echo_cnt",  32'(tx_n1 - b1), 32'd16);
      check("t4_echo_err",  {24'b0, err1}, 32'd1);

      // 5: collision mid-answer, then saturation
      b0 = tx_n0;
      send_byte(8'h10); send_byte(8'h33);
      wait_tx(b0 + 3, "t5_wait_tx");
      send_byte(8'h10);
      wait_idle("t5_idle");
      check("t5_err_inc", {24'b0, err0}, 32'd2);
      check("t5_tx_cnt",  32'(tx_n0 - b0), 32'd16);
      bad = 0;
      for (int i = 0; i < 16; i++) if (log0[b0 + i] !== rom_val({2'd0, 4'(i)})) bad++;
      check("t5_tx_data", 32'(bad), 32'd0);
      send_byte(8'h10); send_byte(8'h33);
      rx_valid = 1'b1; rx_data = 8'h10;
      repeat (300) @(posedge clk);
      #1 rx_valid = 1'b0;
      wait_idle("t5_sat_idle");
      check("t5_sat", {24'b0, err0}, 32'hFF);
      b0 = tx_n0;
      send_byte(8'h10); send_byte(8'h33);
      wait_tx(b0 + 2, "t5_wait_tx2");
      send_byte(8'h10);
      wait_idle("t5_sat_idle2");
      check("t5_sat_hold", {24'b0, err0}, 32'hFF);
      check("t5_sat_cnt",  32'(tx_n0 - b0), 32'd16);

      // 6: asynchronous reset while byte 5 is in flight
      b0 = tx_n0;
      send_byte(8'h12); send_byte(8'h44);
      wait_tx(b0 + 6, "t6_wait_tx");
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("t6_dir_tx", {31'b0, dtx0},  32'd0);
      check("t6_dir_rx", {31'b0, drx0},  32'd1);
      check("t6_busy",   {31'b0, busy0}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      b1 = tx_n0;
      repeat (300) @(negedge clk);
      check("t6_no_tx",  32'(tx_n0 - b1), 32'd0);
      check("t6_err_clr", {24'b0, err0}, 32'd0);
      b0 = tx_n0;
      send_byte(8'h12); send_byte(8'h44);
      wait_idle("t6_idle");
      check("t6_tx_cnt", 32'(tx_n0 - b0), 32'd16);
      check("t6_b0",     {24'b0, log0[b0]},     {24'b0, rom_val(6'h20)});
      check("t6_b5",     {24'b0, log0[b0 + 5]}, {24'b0, rom_val(6'h25)});

      check("dir_rx_compl", 32'(dir_bad), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
